bp_update_scheduler: RTL
========================

# bp_update_scheduler

Sequencer that owns the branch predictor's single update port. It buffers resolved-branch outcomes from the execute stage in a small FIFO and drains them into the predictor's check/update port when the port accepts. It also runs the BHT clear sweep after reset and on a flush request, invalidating every line one per cycle. It sits between the execute-stage branch comparator and the branch predictor in `riscv_core/branch_prediction`.

## Interface
- PC_WIDTH, 32, width of branch PCs
- DEPTH, 4, FIFO entries; power of two, ≥2
- LINES, 128, BHT lines to sweep; power of two, ≥2
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- res_valid  in  1  execute stage presents a resolved branch
- res_pc  in  PC_WIDTH  PC of resolved branch
- res_taken  in  1  actual outcome
- res_ready  out  1  scheduler accepts this cycle; transfer = res_valid && res_ready
- flush  in  1  one-cycle request: drop queue, restart clear sweep
- upd_valid  out  1  drives predictor is_br_check
- upd_pc  out  PC_WIDTH  drives predictor pc_check
- upd_taken  out  1  drives predictor br_taken_check
- upd_ready  in  1  predictor update port free this cycle
- clr_valid  out  1  invalidate BHT line clr_idx this cycle
- clr_idx  out  $clog2(LINES)  line being invalidated
- busy  out  1  high in CLEAR or when FIFO non-empty

## Operation
- States: CLEAR, RUN. Reset → CLEAR, clr_idx=0, FIFO count=0, rd/wr pointers=0.
- CLEAR: clr_valid=1, clr_idx increments by 1 each cycle; after line LINES-1 is issued → RUN next cycle. res_ready=0, upd_valid=0.
- RUN: clr_valid=0; res_ready = (count != DEPTH). upd_valid = (count != 0); upd_pc/upd_taken = FIFO head.
- Enqueue on res_valid && res_ready: write at wr_ptr, wr_ptr+1.
- Dequeue on upd_valid && upd_ready: rd_ptr+1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Full: res_ready=0 even if a dequeue occurs the same cycle (no same-cycle refill).
- Empty: upd_valid=0; an entry enqueued this cycle is not bypassed to the head.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH; count is log2(DEPTH)+1 bits, never exceeds DEPTH or underflows.
- flush (either state): next cycle state=CLEAR, clr_idx=0, count=0, pointers=0. Any enqueue or dequeue in the flush cycle is discarded. flush during CLEAR restarts the sweep from 0.
- reset has priority over flush; flush has priority over enqueue/dequeue.
- upd_pc/upd_taken are don't-care when upd_valid=0 but must not contain X after reset (FIFO storage need not be reset; outputs are gated to 0 when empty).

## Timing
- All outputs are functions of registered state only (plus upd_ready-independent); no combinational path from res_* or upd_ready to any output.
- Values during reset and first cycle after: state CLEAR, clr_valid=1, clr_idx=0, upd_valid=0, upd_pc=0, upd_taken=0, res_ready=0, busy=1.
- Sweep length: exactly LINES cycles of clr_valid=1 (idx 0..LINES-1), then RUN; res_ready can first be 1 on cycle LINES after reset deassertion.
- Accept-to-update latency: entry accepted in cycle N appears on upd_valid in cycle N+1 if FIFO was empty.
- Throughput: one enqueue and one dequeue per cycle sustained.
- upd_valid, once asserted, holds with stable upd_pc/upd_taken until upd_ready or flush.

## Test plan
- Reset, LINES=128 → clr_valid=1 for 128 cycles, clr_idx 0..127 in order, then clr_valid=0, res_ready=1, busy=0.
- RUN, upd_ready=1, enqueue pc=0x100 taken=1 at cycle N → upd_valid=1, upd_pc=0x100, upd_taken=1 at N+1; busy=0 at N+2.
- upd_ready=0, enqueue 0x10,0x14,0x18,0x1C,0x20 on consecutive cycles → first four accepted, res_ready=0 on fifth; raise upd_ready → drained in order 0x10..0x1C, one per cycle.
- FIFO full, simultaneous res_valid and upd_ready → dequeue occurs, enqueue refused, count=3; continuous streaming 20 entries with upd_ready=1 → all 20 emerge in order, pointers wrap correctly.
- Three entries queued, pulse flush with res_valid=1 → next cycle upd_valid=0, clr_valid=1, clr_idx=0, queued and concurrent entries never appear on upd_*.
- flush asserted at clr_idx=50 → clr_idx returns to 0 next cycle, sweep completes 128 more cycles before RUN.

Source files
------------

// File: rtl/bp_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_scheduler
// Purpose  : Owns the branch predictor's single update port. Buffers
//            resolved-branch outcomes in a small FIFO and drains them into
//            the predictor's check/update port. Runs the BHT clear sweep
//            after reset and on flush.
// Revision : 1.0 - initial release
// ============================================================================
module bp_update_scheduler #(
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 4,
    parameter int LINES    = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     res_valid,
    input  logic [PC_WIDTH-1:0]      res_pc,
    input  logic                     res_taken,
    output logic                     res_ready,
    input  logic                     flush,
    output logic                     upd_valid,
    output logic [PC_WIDTH-1:0]      upd_pc,
    output logic                     upd_taken,
    input  logic                     upd_ready,
    output logic                     clr_valid,
    output logic [$clog2(LINES)-1:0] clr_idx,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = $clog2(LINES);

    localparam logic [0:0]       c_CLEAR    = 1'b0;
    localparam logic [0:0]       c_RUN      = 1'b1;
    localparam logic [PTR_W:0]   c_FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   c_ONE_CNT  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_ONE_PTR  = PTR_W'(1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(LINES - 1);
    localparam logic [IDX_W-1:0] c_ONE_IDX  = IDX_W'(1);

    logic [0:0]       state_q,   state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [PTR_W:0]   count_q,   count_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;

    // Entry layout: {taken, pc}. Storage is deliberately not reset.
    logic [PC_WIDTH:0] mem_q [DEPTH];

    logic w_run;
    logic w_not_full;
    logic w_not_empty;
    logic w_enq;
    logic w_deq;
    logic [PC_WIDTH:0] w_head;

    assign w_run       = (state_q == c_RUN);
    assign w_not_full  = (count_q != c_FULL_CNT);
    assign w_not_empty = (count_q != '0);

    // Handshakes use only registered-state outputs, so a full FIFO never
    // refills in the same cycle it drains.
    assign w_enq = res_valid && res_ready;
    assign w_deq = upd_valid && upd_ready;

    assign w_head = mem_q[rd_ptr_q];

    assign res_ready = w_run && w_not_full;
    assign upd_valid = w_run && w_not_empty;
    assign upd_pc    = upd_valid ? w_head[PC_WIDTH-1:0] : '0;
    assign upd_taken = upd_valid ? w_head[PC_WIDTH]     : 1'b0;
    assign clr_valid = (state_q == c_CLEAR);
    assign clr_idx   = clr_idx_q;
    assign busy      = (state_q == c_CLEAR) || w_not_empty;

    // Next-state logic: flush wipes the queue and restarts the sweep, and
    // takes priority over any enqueue/dequeue in the same cycle.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (flush) begin
            state_d   = c_CLEAR;
            clr_idx_d = '0;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else if (state_q == c_CLEAR) begin
            clr_idx_d = clr_idx_q + c_ONE_IDX;
            if (clr_idx_q == c_LAST_IDX) begin
                state_d = c_RUN;
            end
        end else begin
            if (w_enq) begin
                wr_ptr_d = wr_ptr_q + c_ONE_PTR;
            end
            if (w_deq) begin
                rd_ptr_d = rd_ptr_q + c_ONE_PTR;
            end
            if (w_enq && !w_deq) begin
                count_d = count_q + c_ONE_CNT;
            end else if (w_deq && !w_enq) begin
                count_d = count_q - c_ONE_CNT;
            end
        end
    end

    // State registers with synchronous reset into the clear sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= c_CLEAR;
            clr_idx_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // FIFO storage write; a write during flush is dropped with the queue.
    always_ff @(posedge clk) begin
        if (w_enq && !flush && !reset) begin
            mem_q[wr_ptr_q] <= {res_taken, res_pc};
        end
    end

endmodule
`default_nettype wire
